// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and helpers for the parallel-in/serial-out transmitter
package piso_pkg;

  typedef enum logic {IDLE, SHIFT} piso_state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// rtl/piso_hold_buf.sv - one-entry holding buffer that lets the next word wait behind the shifter
module piso_hold_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 1'b0;
      rd_data <= '0;
    end else if (wr_en) begin
      full    <= 1'b1;
      rd_data <= wr_data;
    end else if (rd_en) begin
      full    <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - word-in, bit-out transmitter with gap-free back-to-back framing
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p_in,
  output logic             out_valid,
  output logic             s_out,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  piso_state_e      state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             xfer;
  logic             last_edge;

  assign xfer      = in_valid & in_ready;
  assign last_edge = (state == SHIFT) && (cnt == LAST_CNT);
  assign shreg_next = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  // in_ready comes straight from the hold flag flop, so in_valid never reaches it.
  assign in_ready  = ~hold_full;
  assign out_valid = (state == SHIFT);
  assign s_out     = out_valid & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign out_last  = last_edge;
  assign busy      = (state == SHIFT) | hold_full;

  piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (xfer && (state == SHIFT) && !last_edge),
    .wr_data (p_in),
    .rd_en   (last_edge && hold_full),
    .rd_data (hold_data),
    .full    (hold_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (xfer) begin
            shreg <= p_in;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (last_edge) begin
            // A held word wins over a word arriving on this same edge.
            cnt <= '0;
            if (hold_full) begin
              shreg <= hold_data;
            end else if (xfer) begin
              shreg <= p_in;
            end else begin
              state <= IDLE;
            end
          end else begin
            shreg <= shreg_next;
            cnt   <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - directed bench for piso_tx (MSB-first 4-bit and LSB-first 8-bit builds)
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, s_out, out_last, busy;
  logic [3:0] p_in;
  logic       in_valid8, in_ready8, out_valid8, s_out8, out_last8, busy8;
  logic [7:0] p_in8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .p_in(p_in),
    .out_valid(out_valid), .s_out(s_out), .out_last(out_last), .busy(busy)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .p_in(p_in8),
    .out_valid(out_valid8), .s_out(s_out8), .out_last(out_last8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loopback monitor: reassembles MSB-first words and matches them against sent order.
  logic       mon_en = 1'b0;
  logic [3:0] acc;
  logic [3:0] exp_q[$];
  int         rx_cnt = 0;

  always @(negedge clk) begin
    if (mon_en && out_valid) begin
      acc = {acc[2:0], s_out};
      if (out_last) begin
        rx_cnt++;
        if (exp_q.size() == 0) check("rx_extra", 32'd1, 32'd0);
        else check("rx_word", {28'd0, acc}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  logic [3:0]  bits4;
  logic [7:0]  bits8;
  logic [7:0]  seq8;
  logic [3:0]  words [10] = '{4'h0, 4'hF, 4'h6, 4'h9, 4'h1, 4'h8, 4'hE, 4'h7, 4'h3, 4'hB};

  initial begin
    rst = 1'b1; in_valid = 1'b0; p_in = '0; in_valid8 = 1'b0; p_in8 = '0;
    tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_busy",      busy,      1'b0);
    check("rst_s_out",     s_out,     1'b0);
    check("rst_out_last",  out_last,  1'b0);

    // Single word 1011: bits in cycles 1..4, idle again in cycle 5.
    in_valid = 1'b1; p_in = 4'b1011;
    tick();
    in_valid = 1'b0;
    bits4 = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      check("single_valid", out_valid, 1'b1);
      check("single_bit",   s_out,     bits4[3-i]);
      check("single_last",  out_last,  (i == 3));
      tick();
    end
    check("single_end_valid", out_valid, 1'b0);
    check("single_end_sout",  s_out,     1'b0);

    // Back-to-back A then 5 with no gap.
    in_valid = 1'b1; p_in = 4'hA;
    tick();
    p_in = 4'h5;
    seq8 = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) in_valid = 1'b0;
      check("b2b_valid", out_valid, 1'b1);
      check("b2b_bit",   s_out,     seq8[7-i]);
      check("b2b_last",  out_last,  (i == 3 || i == 7));
      if (i >= 1 && i <= 3) check("b2b_ready_low", in_ready, 1'b0);
      if (i == 4) check("b2b_ready_back", in_ready, 1'b1);
      tick();
    end
    check("b2b_end_valid", out_valid, 1'b0);

    // Collision: 3 offered exactly on the last-bit edge of C.
    in_valid = 1'b1; p_in = 4'hC;
    tick();
    in_valid = 1'b0;
    seq8 = 8'b1100_0011;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        check("coll_ready_at_last", in_ready, 1'b1);
        in_valid = 1'b1; p_in = 4'h3;
      end
      if (i == 4) in_valid = 1'b0;
      check("coll_valid", out_valid, 1'b1);
      check("coll_bit",   s_out,     seq8[7-i]);
      tick();
    end
    check("coll_end_valid", out_valid, 1'b0);

    // Reset mid-word: F shifting, 9 held, reset after bit 2.
    in_valid = 1'b1; p_in = 4'hF;
    tick();
    p_in = 4'h9;
    tick();
    in_valid = 1'b0;
    check("rmid_held", in_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmid_out_valid", out_valid, 1'b0);
    check("rmid_in_ready",  in_ready,  1'b1);
    check("rmid_busy",      busy,      1'b0);
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        if (out_valid) seen++;
        tick();
      end
      check("rmid_no_resend", seen, 0);
    end

    // LSB-first 8-bit build: 0x81.
    in_valid8 = 1'b1; p_in8 = 8'h81;
    tick();
    in_valid8 = 1'b0;
    bits8 = 8'b1000_0001;
    for (int i = 0; i < 8; i++) begin
      check("w8_valid", out_valid8, 1'b1);
      check("w8_bit",   s_out8,     bits8[i]);
      check("w8_last",  out_last8,  (i == 7));
      tick();
    end
    check("w8_end_valid", out_valid8, 1'b0);

    // Loopback with random gaps between offers.
    acc = '0;
    mon_en = 1'b1;
    for (int w = 0; w < 10; w++) begin
      int gap;
      int guard;
      gap = $urandom_range(0, 5);
      if (gap != 0) begin
        in_valid = 1'b0;
        repeat (gap) tick();
      end
      in_valid = 1'b1; p_in = words[w];
      guard = 0;
      while (!in_ready && guard < 20) begin
        tick();
        guard++;
      end
      if (guard >= 20) check("lb_ready_timeout", 32'd1, 32'd0);
      exp_q.push_back(words[w]);
      tick();
      in_valid = 1'b0;
    end
    begin
      int guard = 0;
      while ((exp_q.size() != 0 || busy) && guard < 60) begin
        tick();
        guard++;
      end
      if (guard >= 60) check("lb_drain_timeout", 32'd1, 32'd0);
    end
    tick();
    mon_en = 1'b0;
    check("lb_word_count", rx_cnt, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
